// File: rtl/imem_responder.sv
// Fixed-latency, in-order memory responder for the mem_in/mem_out fetch protocol.
// Optional squash-on-fence/spec behaviour is enabled by defining IMEM_RESPONDER_SQUASH_EN.
module imem_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_fence,
    input  logic        mem_spec,
    input  logic        mem_instr,
    input  logic [1:0]  mem_mode,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        mem_ready,
    output logic        busy
);

    localparam int unsigned AW   = $clog2(MEM_WORDS);
    localparam int unsigned CW   = $clog2(LATENCY + 1) + 1;
    localparam logic [32:0] SPAN = 33'(MEM_WORDS) * 33'd4;

    logic [31:0]        mem_q [MEM_WORDS];
    logic [31:0]        off;
    logic [AW-1:0]      idx;
    logic               oor;
    logic               is_wr;
    logic               err;
    logic               wr_en;
    logic               squash;
    logic [31:0]        rd_word;

    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic [31:0]        dat_q [LATENCY];
    logic [LATENCY-1:0] err_q;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic               busy_q;

    always_comb begin
        off     = mem_addr - BASE_ADDR;
        idx     = off[AW+1:2];
        oor     = {1'b0, off} >= SPAN;
        is_wr   = |mem_wstrb;
        err     = oor | (is_wr & mem_instr);
        wr_en   = mem_valid & is_wr & ~err;
        rd_word = mem_q[idx];
    end

`ifdef IMEM_RESPONDER_SQUASH_EN
    logic unused_sig;
    assign unused_sig = ^mem_mode;
    always_comb squash = mem_valid & (mem_fence | mem_spec);
`else
    logic unused_sig;
    assign unused_sig = ^{mem_mode, mem_fence, mem_spec};
    always_comb squash = 1'b0;
`endif

    // Array has no reset; only the response pipeline is cleared.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (mem_wstrb[k]) mem_q[idx][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = mem_valid;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1] & ~squash;
        end
    end

    // The due response is masked combinationally so a squash also kills it at the same edge.
    assign mem_ready = vld_q[LATENCY-1] & ~squash;
    assign mem_rdata = mem_ready ? dat_q[LATENCY-1] : '0;
    assign mem_error = mem_ready & err_q[LATENCY-1];
    assign busy      = busy_q;

    always_comb begin
        cnt_d = cnt_q;
        if (squash) begin
            cnt_d = CW'(1);
        end else if (mem_valid && !mem_ready) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!mem_valid && mem_ready) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q  <= '0;
            err_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            dat_q[0] <= (is_wr || err) ? '0 : rd_word;
            err_q[0] <= err;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                dat_q[i] <= dat_q[i-1];
                err_q[i] <= err_q[i-1];
            end
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != '0);
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder (MEM_WORDS=16, LATENCY=2).
module tb_imem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_valid, mem_fence, mem_spec, mem_instr;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_error, mem_ready, busy;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    imem_responder #(.MEM_WORDS(16), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
        .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_fence(mem_fence),
        .mem_spec(mem_spec), .mem_instr(mem_instr), .mem_mode(mem_mode),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_error(mem_error), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic instr, input logic spec);
        mem_valid = v;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        mem_instr = instr;
        mem_spec  = spec;
    endtask

    task automatic idle();
        req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] f(input int unsigned i);
        return (i == 5) ? 32'hDEADBEEF : 32'hC0DE0000 + i;
    endfunction

    initial begin
        reset = 1'b0;
        mem_fence = 1'b0;
        mem_mode  = 2'b11;
        idle();
        #12;
        chk("rst_ready", {31'b0, mem_ready}, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_error", {31'b0, mem_error}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        reset = 1'b1;

        for (int unsigned i = 0; i < 8; i++) begin
            req(1'b1, i * 4, f(i), 4'hF, 1'b0, 1'b0);
            step();
        end
        req(1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, 1'b0, 1'b0); step();
        req(1'b1, 32'h24, 32'h12345678, 4'hF, 1'b0, 1'b0); step();
        req(1'b1, 32'h3C, 32'h0F0F0F0F, 4'hF, 1'b0, 1'b0); step();
        idle();
        step(); step(); step();
        chk("drain_busy", {31'b0, busy}, 32'h0);

        // Single read latency
        req(1'b1, 32'h14, 32'h0, 4'h0, 1'b0, 1'b0);
        step();
        idle();
        chk("rd_e0_ready", {31'b0, mem_ready}, 32'h0);
        chk("rd_e0_busy", {31'b0, busy}, 32'h1);
        step();
        chk("rd_e1_ready", {31'b0, mem_ready}, 32'h1);
        chk("rd_e1_rdata", mem_rdata, 32'hDEADBEEF);
        chk("rd_e1_error", {31'b0, mem_error}, 32'h0);
        chk("rd_e1_busy", {31'b0, busy}, 32'h1);
        step();
        chk("rd_e2_ready", {31'b0, mem_ready}, 32'h0);
        chk("rd_e2_rdata", mem_rdata, 32'h0);
        chk("rd_e2_busy", {31'b0, busy}, 32'h0);

        // Streaming reads
        for (int unsigned i = 0; i < 8; i++) begin
            req(1'b1, i * 4, 32'h0, 4'h0, 1'b0, 1'b0);
            step();
            if (i == 0) begin
                chk("str_first_ready", {31'b0, mem_ready}, 32'h0);
            end else begin
                chk($sformatf("str_ready%0d", i - 1), {31'b0, mem_ready}, 32'h1);
                chk($sformatf("str_rdata%0d", i - 1), mem_rdata, f(i - 1));
            end
        end
        idle();
        step();
        chk("str_ready7", {31'b0, mem_ready}, 32'h1);
        chk("str_rdata7", mem_rdata, f(7));
        chk("str_busy_tail", {31'b0, busy}, 32'h1);
        step();
        chk("str_end_ready", {31'b0, mem_ready}, 32'h0);
        chk("str_end_busy", {31'b0, busy}, 32'h0);

        // Byte write then read-back next cycle
        req(1'b1, 32'h20, 32'h11223344, 4'b0101, 1'b0, 1'b0);
        step();
        req(1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0);
        step();
        idle();
        chk("bw_wr_ready", {31'b0, mem_ready}, 32'h1);
        chk("bw_wr_rdata", mem_rdata, 32'h0);
        chk("bw_wr_error", {31'b0, mem_error}, 32'h0);
        step();
        chk("bw_rd_ready", {31'b0, mem_ready}, 32'h1);
        chk("bw_rd_rdata", mem_rdata, 32'hAA22AA44);
        step();

        // Boundaries: last word, unaligned low bits, first out-of-range word
        req(1'b1, 32'h3C, 32'h0, 4'h0, 1'b0, 1'b0); step();
        req(1'b1, 32'h17, 32'h0, 4'h0, 1'b0, 1'b0); step();
        chk("last_rdata", mem_rdata, 32'h0F0F0F0F);
        chk("last_error", {31'b0, mem_error}, 32'h0);
        req(1'b1, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0); step();
        chk("unal_rdata", mem_rdata, 32'hDEADBEEF);
        req(1'b1, 32'h24, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0); step();
        chk("oor_ready", {31'b0, mem_ready}, 32'h1);
        chk("oor_error", {31'b0, mem_error}, 32'h1);
        chk("oor_rdata", mem_rdata, 32'h0);
        req(1'b1, 32'h24, 32'h0, 4'h0, 1'b0, 1'b0); step();
        chk("iwr_ready", {31'b0, mem_ready}, 32'h1);
        chk("iwr_error", {31'b0, mem_error}, 32'h1);
        chk("iwr_rdata", mem_rdata, 32'h0);
        idle();
        step();
        chk("iwr_rb_rdata", mem_rdata, 32'h12345678);
        chk("iwr_rb_error", {31'b0, mem_error}, 32'h0);
        step();

        // Asynchronous reset with requests in flight
        req(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        step();
        req(1'b1, 32'h4, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("mr_busy_pre", {31'b0, busy}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("mr_ready", {31'b0, mem_ready}, 32'h0);
        chk("mr_rdata", mem_rdata, 32'h0);
        chk("mr_error", {31'b0, mem_error}, 32'h0);
        chk("mr_busy", {31'b0, busy}, 32'h0);
        req(1'b1, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0);
        step(); step();
        idle();
        reset = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            step();
            chk($sformatf("mr_quiet%0d", i), {30'b0, mem_ready, busy}, 32'h0);
        end

        // Read with mem_spec set after two reads in flight
        req(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0); step();
        req(1'b1, 32'h4, 32'h0, 4'h0, 1'b0, 1'b0); step();
        req(1'b1, 32'h8, 32'h0, 4'h0, 1'b0, 1'b1);
        #1;
`ifdef IMEM_RESPONDER_SQUASH_EN
        chk("sq_a_ready", {31'b0, mem_ready}, 32'h0);
        step();
        idle();
        chk("sq_b_ready", {31'b0, mem_ready}, 32'h0);
        chk("sq_b_busy", {31'b0, busy}, 32'h1);
        step();
`else
        chk("sq_a_ready", {31'b0, mem_ready}, 32'h1);
        chk("sq_a_rdata", mem_rdata, f(0));
        step();
        idle();
        chk("sq_b_ready", {31'b0, mem_ready}, 32'h1);
        chk("sq_b_rdata", mem_rdata, f(1));
        step();
`endif
        chk("sq_c_ready", {31'b0, mem_ready}, 32'h1);
        chk("sq_c_rdata", mem_rdata, f(2));
        chk("sq_c_busy", {31'b0, busy}, 32'h1);
        step();
        chk("sq_end_ready", {31'b0, mem_ready}, 32'h0);
        chk("sq_end_busy", {31'b0, busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
